// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the rv32 exec load/store handshake.
// Optional MMIO tohost/print port enabled with `define DMEM_MMIO_EN.
module dmem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_req_vld,
  output logic        d_req_rdy,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_rsp_vld,
  input  logic        d_rsp_rdy,
  output logic [31:0] d_rdata,
  output logic        d_err
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_data,
  output logic        mmio_stb
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_acc;
  logic          w_go;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [31:0]   w_off;
  logic          w_inr;
  logic [AW-1:0] w_idx;
  logic          w_be_ok;
  logic          w_bad;
  logic          w_err;
  logic          w_mwr;
  logic [31:0]   w_mask;
  logic [31:0]   w_rword;

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = w_idle & d_req_vld;

  // With zero wait states the array is touched on the accept edge itself,
  // so the request is taken straight from the ports in that case.
  assign w_go = w_idle ? (w_acc && (WAIT_STATES == 0))
                       : ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_we    = w_idle ? d_we    : r_we;
  assign w_addr  = w_idle ? d_addr  : r_addr;
  assign w_wdata = w_idle ? d_wdata : r_wdata;
  assign w_be    = w_idle ? d_be    : r_be;

  assign w_off = w_addr - ADDR_BASE;
  assign w_inr = {1'b0, w_off} < LIMIT;
  assign w_idx = w_off[AW+1:2];

  always_comb begin
    w_be_ok = 1'b0;
    unique case (w_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
      default:                   w_be_ok = 1'b0;
    endcase
  end

  assign w_bad  = (w_addr[1:0] != 2'b00) | (w_we & ~w_be_ok);
  assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

`ifdef DMEM_MMIO_EN
  logic        r_mmio_data;
  logic [31:0] r_mmio_q;
  logic        w_hit;

  assign w_hit   = (w_addr == 32'hFFFF_FFF0);
  assign w_err   = w_bad | (~w_inr & ~w_hit);
  assign w_mwr   = w_go & w_we & ~w_err & ~w_hit;
  assign w_rword = w_hit ? r_mmio_q : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mmio_q    <= 32'd0;
      r_mmio_data <= 1'b0;
    end else begin
      r_mmio_data <= w_go & w_we & ~w_err & w_hit;
      if (w_go & w_we & ~w_err & w_hit)
        r_mmio_q <= (r_mmio_q & ~w_mask) | (w_wdata & w_mask);
    end
  end

  assign mmio_data = r_mmio_q;
  assign mmio_stb  = r_mmio_data;
`else
  assign w_err   = w_bad | ~w_inr;
  assign w_mwr   = w_go & w_we & ~w_err;
  assign w_rword = r_mem[w_idx];
`endif

  // Array is never reset so preloaded images survive.
  always_ff @(posedge clk) begin
    if (rst_n && w_mwr)
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_wdata & w_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_be    <= d_be;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          if (d_rsp_rdy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_go) begin
        r_err   <= w_err;
        r_rdata <= (w_err | w_we) ? 32'd0 : w_rword;
      end
    end
  end

  assign d_req_rdy = w_idle;
  assign d_rsp_vld = (r_state == S_RESP);
  assign d_rdata   = r_rdata;
  assign d_err     = r_err;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed vector bench for dmem_resp (WAIT_STATES=1).
// Build with DMEM_MMIO_EN defined to exercise the MMIO port.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_req_vld;
  logic        d_req_rdy;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_rsp_vld;
  logic        d_rsp_rdy;
  logic [31:0] d_rdata;
  logic        d_err;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_data;
  logic        mmio_stb;
  int          stb_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_resp #(
    .DEPTH_WORDS(1024),
    .ADDR_BASE  (32'h0000_0000),
    .WAIT_STATES(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_req_vld(d_req_vld),
    .d_req_rdy(d_req_rdy),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rsp_vld(d_rsp_vld),
    .d_rsp_rdy(d_rsp_rdy),
    .d_rdata  (d_rdata),
    .d_err    (d_err)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_data(mmio_data),
    .mmio_stb (mmio_stb)
`endif
  );

`ifdef DMEM_MMIO_EN
  always @(posedge clk) if (mmio_stb) stb_cnt = stb_cnt + 1;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    d_req_vld = 1'b1;
    d_we      = we;
    d_addr    = a;
    d_wdata   = wd;
    d_be      = be;
    @(posedge clk);
    #1;
    d_req_vld = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h5555_5555;
    lat       = 1;
    while (!d_rsp_vld && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = d_rdata;
    er = d_err;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] hold_rd;
  logic        hold_er;

  initial begin
    rst_n     = 1'b0;
    d_req_vld = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'd0;
    d_wdata   = 32'd0;
    d_be      = 4'd0;
    d_rsp_rdy = 1'b1;

    tv.push_back('{1'b1, 32'h008, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h008, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0});
    tv.push_back('{1'b1, 32'h010, 32'h1122_3344, 4'b1111, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h010, 32'h00AA_0000, 4'b0100, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h010, 32'h0, 4'b0000, 32'h11AA_3344, 1'b0});
    tv.push_back('{1'b0, 32'h006, 32'h0, 4'b0000, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'hFFC, 32'h1234_5678, 4'b1111, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'hFFC, 32'h0, 4'b0000, 32'h1234_5678, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h014, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h016, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'h014, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'h0000_1234, 4'b0011, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h014, 32'h0, 4'b0000, 32'hCAFE_1234, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'hBEEF_0000, 4'b1100, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'h0000_0055, 4'b0001, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'h0000_6600, 4'b0010, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h014, 32'h7700_0000, 4'b1000, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h014, 32'h0, 4'b0000, 32'h77EF_6655, 1'b0});
    tv.push_back('{1'b1, 32'h020, 32'h0000_0000, 4'b1111, 32'h0, 1'b0});
`ifdef DMEM_MMIO_EN
    tv.push_back('{1'b1, 32'hFFFF_FFF0, 32'h0000_0041, 4'b0001, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'hFFFF_FFF0, 32'h0, 4'b0000, 32'h41, 1'b0});
`else
    tv.push_back('{1'b1, 32'hFFFF_FFF0, 32'h0000_0041, 4'b0001, 32'h0, 1'b1});
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", {31'd0, d_req_rdy}, 32'd1);
    chk("rst_rsp_vld", {31'd0, d_rsp_vld}, 32'd0);
    chk("rst_rdata", d_rdata, 32'd0);
    chk("rst_err", {31'd0, d_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      txn(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be, rd, er, lat);
      chk($sformatf("v%0d_lat", i), lat, 32'd2);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tv[i].exp_err});
    end

`ifdef DMEM_MMIO_EN
    chk("mmio_data", mmio_data, 32'h41);
    chk("mmio_stb_cnt", stb_cnt, 32'd1);
`endif

    // backpressure: hold rsp_rdy low 5 cycles
    @(negedge clk);
    d_rsp_rdy = 1'b0;
    d_req_vld = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h008;
    @(posedge clk);
    #1;
    d_req_vld = 1'b0;
    lat = 1;
    while (!d_rsp_vld && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat", lat, 32'd2);
    hold_rd = d_rdata;
    hold_er = d_err;
    chk("bp_rdata", hold_rd, 32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_c%0d_vld", c), {31'd0, d_rsp_vld}, 32'd1);
      chk($sformatf("bp_c%0d_rdy", c), {31'd0, d_req_rdy}, 32'd0);
      chk($sformatf("bp_c%0d_rd", c), d_rdata, 32'hDEAD_BEEF);
      chk($sformatf("bp_c%0d_er", c), {31'd0, d_err}, {31'd0, hold_er});
      if (c < 4) begin
        @(posedge clk);
        #1;
      end
    end
    d_rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done_vld", {31'd0, d_rsp_vld}, 32'd0);
    chk("bp_done_rdy", {31'd0, d_req_rdy}, 32'd1);

    // reset during WAIT of a store to 0x20 (holding 0)
    @(negedge clk);
    d_req_vld = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h020;
    d_wdata   = 32'hFFFF_FFFF;
    d_be      = 4'b1111;
    @(posedge clk);
    #1;
    d_req_vld = 1'b0;
    chk("mr_in_wait", {31'd0, d_req_rdy}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_rsp_vld", {31'd0, d_rsp_vld}, 32'd0);
    chk("mr_req_rdy", {31'd0, d_req_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 32'h020, 32'h0, 4'b0000, rd, er, lat);
    chk("mr_load_rd", rd, 32'h0);
    chk("mr_load_err", {31'd0, er}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder for the rv32 core: the target end of the exec load/store request/response handshake.
- Accepts one word-aligned read or write request at a time and holds an internal word-addressed SRAM array.
- Inserts a programmable number of wait states, then returns read data or a write acknowledge.
- Out-of-range and illegal requests are reported through an error flag rather than dropped.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, >= 2.
- ADDR_BASE, 32'h0000_0000: byte address of word 0; must be DEPTH_WORDS*4 aligned.
- WAIT_STATES, 1: cycles spent in WAIT between accept and response; 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- d_req_vld  in  1  exec presents a request.
- d_req_rdy  out  1  responder can accept a request this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  byte address; bits [1:0] must be 0.
- d_wdata  in  32  store data, lane-aligned.
- d_be  in  4  byte enables for stores; ignored for loads.
- d_rsp_vld  out  1  response valid.
- d_rsp_rdy  in  1  exec accepts the response.
- d_rdata  out  32  load data, full word; exec does lane select and sign extension.
- d_err  out  1  response is an error; qualified by d_rsp_vld.

Behaviour:
- Reset: synchronous on rising clk when rst_n=0; overrides all other activity, including mid-transaction.
  - Outputs after reset: d_req_rdy=1, d_rsp_vld=0, d_rdata=0, d_err=0; FSM in IDLE; wait counter=0.
  - Array contents are not cleared, so preloaded images survive reset.
  - An in-flight store whose array write has not yet occurred is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - d_req_rdy=1.
  - On d_req_vld&d_req_rdy, latch we/addr/wdata/be.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - d_req_rdy=0.
  - Counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - At 0, go to RESP.
- RESP entry cycle:
  - Array access and error check use the latched request.
  - d_rsp_vld=1 from the first cycle in RESP.
- RESP hold:
  - d_rdata and d_err stay stable while d_rsp_vld=1 and d_rsp_rdy=0.
  - On d_rsp_vld&d_rsp_rdy, go to IDLE; d_rsp_vld deasserts the next cycle.
- Latency: request accept edge to d_rsp_vld high = WAIT_STATES+1 cycles.
  - Back-to-back throughput is one transaction per WAIT_STATES+2 cycles minimum.
  - d_req_rdy is high only in IDLE, so no request is accepted while a response is pending.
- Address decode:
  - Word index = (addr-ADDR_BASE)>>2.
  - In range iff ADDR_BASE <= addr < ADDR_BASE+DEPTH_WORDS*4.
  - Wrap-around past the top is not permitted: the final word is valid, final+4 is an error.
- Error cases (d_err=1):
  - Out-of-range address.
  - addr[1:0]!=0.
  - Store with d_be=0.
  - Store with d_be not in {0001,0010,0100,1000,0011,1100,1111}.
- Error handling:
  - On error, the array is not written and d_rdata=0.
- Store:
  - Written in the RESP entry cycle, only byte lanes with be=1; other bytes preserved.
  - d_rdata=0 for stores.
- Load:
  - d_rdata = full addressed word, read in the RESP entry cycle.
- Signals are ignored while not being sampled: d_req_* outside the IDLE handshake, d_rsp_rdy outside RESP.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Adds outputs mmio_data[31:0] and mmio_stb[0:0].
  - A legal store to byte address 32'hFFFF_FFF0 is not an error.
  - Its enabled lanes update mmio_data; mmio_stb pulses high for exactly one cycle in the RESP entry cycle.
  - A load from 32'hFFFF_FFF0 returns mmio_data.
  - Reset: mmio_data=0, mmio_stb=0.
  - Used by benches as a tohost/print port.
- Undefined:
  - Ports are absent.
  - 32'hFFFF_FFF0 is decoded like any other address: an out-of-range error unless it falls inside the array.

Test Plan:
- WAIT_STATES=1: store addr 0x8, wdata 0xDEADBEEF, be 1111, then load 0x8.
  - -> d_rsp_vld 2 cycles after each accept; load d_rdata=0xDEADBEEF, d_err=0.
- Byte-lane store over 0x11223344 at 0x10 with be=0100, wdata 0x00AA0000, then load 0x10.
  - -> d_rdata=0x11AA3344.
- Load addr 0x6 (misaligned); load addr ADDR_BASE+DEPTH_WORDS*4 (one past top).
  - -> d_err=1, d_rdata=0, array unchanged; a load of the last valid word succeeds.
- Backpressure: hold d_rsp_rdy=0 for 5 cycles after d_rsp_vld rises.
  - -> d_rdata/d_err stable, d_req_rdy=0 throughout; response completes on the first rdy cycle and d_req_rdy returns 1 the cycle after.
- Reset mid-transaction: assert rst_n=0 during WAIT of a store to 0x20 holding 0x0.
  - -> next cycle d_rsp_vld=0, d_req_rdy=1; a later load of 0x20 returns 0x0.
- DMEM_MMIO_EN defined: store 0x41 be 0001 to 0xFFFF_FFF0.
  - -> mmio_stb one-cycle pulse, mmio_data=0x41, d_err=0.
  - Without the macro the same store gives d_err=1.
